iobus_dma: RTL

IOBUS_DMA -- requirements
Module: iobus_dma

---
 rtl/iobus_dma.sv | 125 ++++++++++++
 1 files changed

// File: rtl/iobus_dma.sv
// iobus_dma -- single-channel word DMA engine on the IOBUS.
//
// Moves LEN 32-bit words from SRC_ADDR to DST_ADDR. Each word is moved as one
// atomic READ/WRITE pair. The address of each side either advances by
// ADDR_STEP after every word or stays fixed, which is how an I/O port is
// addressed.
//
// Ports:
//   CLK, RESET_N             clock, asynchronous active-low reset
//   START, ABORT             begin a transfer (sampled in IDLE) / cancel it
//   SRC_ADDR, DST_ADDR, LEN  transfer descriptor, latched on an accepted START
//   SRC_INC, DST_INC         per-side address increment enables
//   BUS_REQ, BUS_GNT         IOBUS arbitration handshake
//   IOBUS_ADDR, IOBUS_OUT,
//   IOBUS_WR, IOBUS_IN       IOBUS address, write data, write strobe, read data
//   BUSY, DONE               engine active / one-cycle completion pulse
module iobus_dma #(
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic [31:0] SRC_ADDR,
  input  logic [31:0] DST_ADDR,
  input  logic [15:0] LEN,
  input  logic        SRC_INC,
  input  logic        DST_INC,
  output logic        BUS_REQ,
  input  logic        BUS_GNT,
  output logic [31:0] IOBUS_ADDR,
  output logic [31:0] IOBUS_OUT,
  output logic        IOBUS_WR,
  input  logic [31:0] IOBUS_IN,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARB   = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  logic [2:0]  state;
  logic [31:0] src_ptr;
  logic [31:0] dst_ptr;
  logic [31:0] data;
  logic [15:0] count;
  logic        src_inc;
  logic        dst_inc;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      data    <= '0;
      count   <= '0;
      src_inc <= 1'b0;
      dst_inc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // ABORT outranks a simultaneous START.
          if (START && !ABORT) begin
            src_ptr <= SRC_ADDR;
            dst_ptr <= DST_ADDR;
            count   <= LEN;
            src_inc <= SRC_INC;
            dst_inc <= DST_INC;
            state   <= (LEN == '0) ? FIN : ARB;
          end
        end
        ARB: begin
          if (ABORT)        state <= IDLE;
          else if (BUS_GNT) state <= READ;
        end
        READ: begin
          // Grant is not looked at here: the READ/WRITE pair is atomic.
          data  <= IOBUS_IN;
          state <= ABORT ? IDLE : WRITE;
        end
        WRITE: begin
          // The write on the bus this cycle always completes; ABORT only
          // redirects the next state and suppresses DONE.
          count <= count - 16'd1;
          if (src_inc) src_ptr <= src_ptr + ADDR_STEP;
          if (dst_inc) dst_ptr <= dst_ptr + ADDR_STEP;
          if (ABORT)                state <= IDLE;
          else if (count == 16'd1)  state <= FIN;
          else if (BUS_GNT)         state <= READ;
          else                      state <= ARB;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state only, so reset clears them at once.
  always_comb begin
    BUS_REQ    = 1'b0;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;
    BUSY       = (state != IDLE);
    DONE       = (state == FIN);
    case (state)
      ARB:  BUS_REQ = 1'b1;
      READ: begin
        BUS_REQ    = 1'b1;
        IOBUS_ADDR = src_ptr;
      end
      WRITE: begin
        BUS_REQ    = 1'b1;
        IOBUS_ADDR = dst_ptr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
